// File: rtl/axi4_usr_mem_arb.sv
// Round-robin arbiter that shares one single-port synchronous SRAM between
// NUM_PORT AXI4 slave user interfaces. A port keeps the SRAM for a whole
// burst; the read data path is broadcast and qualified by the per-port rvalid.
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif

module axi4_usr_mem_arb #(
  parameter int NUM_PORT = 2,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = `AXI4_DATA_WIDTH
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_PORT-1:0]        p_awvalid_i,
  input  logic [NUM_PORT-1:0]        p_arvalid_i,
  input  logic [NUM_PORT*8-1:0]      p_arlen_i,
  input  logic [NUM_PORT-1:0]        p_wvalid_i,
  input  logic [NUM_PORT-1:0]        p_wlast_i,
  input  logic [NUM_PORT-1:0]        p_rready_i,
  input  logic [NUM_PORT-1:0]        p_bready_i,
  input  logic [NUM_PORT-1:0]        p_en_i,
  input  logic [NUM_PORT-1:0]        p_wen_i,
  input  logic [NUM_PORT*ADDR_W-1:0] p_addr_i,
  input  logic [NUM_PORT*DATA_W/8-1:0] p_bm_i,
  input  logic [NUM_PORT*DATA_W-1:0] p_dat_i,
  output logic [NUM_PORT-1:0]        p_awready_o,
  output logic [NUM_PORT-1:0]        p_wready_o,
  output logic [NUM_PORT-1:0]        p_bvalid_o,
  output logic [NUM_PORT-1:0]        p_arready_o,
  output logic [NUM_PORT-1:0]        p_rvalid_o,
  output logic [DATA_W-1:0]          p_dat_o,
  output logic                       mem_en_o,
  output logic                       mem_wen_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W/8-1:0]        mem_bm_o,
  output logic [DATA_W-1:0]          mem_dat_o,
  input  logic [DATA_W-1:0]          mem_dat_i
);

  localparam int PW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam int BW = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, GRANT, RD, WR, RESP} state_t;

  state_t          state;
  logic [PW-1:0]   gnt;
  logic [PW-1:0]   rr_ptr;
  logic [7:0]      len_q;
  logic [8:0]      beat_cnt;
  logic            rd_pend_q;

  logic [NUM_PORT-1:0] req;
  logic [PW-1:0]       pick;
  logic                pick_vld;
  logic [PW:0]         pick_sum;
  logic [PW-1:0]       gnt_inc;

  // Signals of the currently granted port
  logic              g_arvalid, g_awvalid, g_wvalid, g_wlast;
  logic              g_rready, g_bready, g_en, g_wen;
  logic [7:0]        g_arlen;
  logic [ADDR_W-1:0] g_addr;
  logic [BW-1:0]     g_bm;
  logic [DATA_W-1:0] g_dat;

  assign req       = p_awvalid_i | p_arvalid_i;
  assign g_arvalid = p_arvalid_i[gnt];
  assign g_awvalid = p_awvalid_i[gnt];
  assign g_wvalid  = p_wvalid_i[gnt];
  assign g_wlast   = p_wlast_i[gnt];
  assign g_rready  = p_rready_i[gnt];
  assign g_bready  = p_bready_i[gnt];
  assign g_en      = p_en_i[gnt];
  assign g_wen     = p_wen_i[gnt];
  assign g_arlen   = p_arlen_i[int'(gnt)*8 +: 8];
  assign g_addr    = p_addr_i[int'(gnt)*ADDR_W +: ADDR_W];
  assign g_bm      = p_bm_i[int'(gnt)*BW +: BW];
  assign g_dat     = p_dat_i[int'(gnt)*DATA_W +: DATA_W];

  // Next round-robin position after the port that just finished a burst
  assign gnt_inc = (gnt == PW'(NUM_PORT - 1)) ? '0 : gnt + 1'b1;

  // Cyclic search for the first requester at or after the rr pointer
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    pick_sum = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      pick_sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (pick_sum >= (PW+1)'(NUM_PORT)) pick_sum = pick_sum - (PW+1)'(NUM_PORT);
      if (!pick_vld && req[pick_sum[PW-1:0]]) begin
        pick     = pick_sum[PW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  // Arbitration / burst-ownership state machine
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          rd_pend_q <= 1'b0;
          if (pick_vld) begin
            gnt   <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          // A read request wins over a write request from the same port
          if (g_arvalid) begin
            len_q    <= g_arlen;
            beat_cnt <= '0;
            state    <= RD;
          end else if (g_awvalid) begin
            state <= WR;
          end else begin
            state <= IDLE;
          end
        end
        RD: begin
          // Read data appears one cycle after en and stays pending until taken
          rd_pend_q <= (g_en & ~g_wen) | (rd_pend_q & ~g_rready);
          if (rd_pend_q && g_rready) begin
            if (beat_cnt == {1'b0, len_q}) begin
              rr_ptr    <= gnt_inc;
              rd_pend_q <= 1'b0;
              state     <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 9'd1;
            end
          end
        end
        WR: begin
          if (g_wvalid && g_wlast) state <= RESP;
        end
        RESP: begin
          if (g_bready) begin
            rr_ptr <= gnt_inc;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-port handshakes and SRAM mux, decoded from the registered state
  always_comb begin
    p_arready_o = '0;
    p_awready_o = '0;
    p_rvalid_o  = '0;
    p_wready_o  = '0;
    p_bvalid_o  = '0;
    mem_en_o    = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_bm_o    = '0;
    mem_dat_o   = '0;
    unique case (state)
      GRANT: begin
        p_arready_o[gnt] = g_arvalid;
        p_awready_o[gnt] = ~g_arvalid & g_awvalid;
      end
      RD:      p_rvalid_o[gnt] = rd_pend_q;
      WR:      p_wready_o[gnt] = 1'b1;
      RESP:    p_bvalid_o[gnt] = 1'b1;
      default: ;
    endcase
    if (state == GRANT || state == RD || state == WR) begin
      mem_en_o   = g_en;
      mem_wen_o  = g_wen;
      mem_addr_o = g_addr;
      mem_bm_o   = g_bm;
      mem_dat_o  = g_dat;
    end
  end

  // Read data is only driven while a beat is being offered
  assign p_dat_o = (state == RD && rd_pend_q) ? mem_dat_i : '0;

endmodule

// File: tb/tb_axi4_usr_mem_arb.sv
// Randomized bench for axi4_usr_mem_arb: per-port slave drivers, an SRAM
// model, and a transaction-level reference (round-robin order, read-over-write
// priority, expected memory image).
module tb_axi4_usr_mem_arb;

  localparam int NP = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic                aclk;
  logic                aresetn;
  logic [NP-1:0]       p_awvalid_i, p_arvalid_i, p_wvalid_i, p_wlast_i;
  logic [NP-1:0]       p_rready_i, p_bready_i, p_en_i, p_wen_i;
  logic [NP*8-1:0]     p_arlen_i;
  logic [NP*AW-1:0]    p_addr_i;
  logic [NP*BW-1:0]    p_bm_i;
  logic [NP*DW-1:0]    p_dat_i;
  logic [NP-1:0]       p_awready_o, p_wready_o, p_bvalid_o, p_arready_o, p_rvalid_o;
  logic [DW-1:0]       p_dat_o;
  logic                mem_en_o, mem_wen_o;
  logic [AW-1:0]       mem_addr_o;
  logic [BW-1:0]       mem_bm_o;
  logic [DW-1:0]       mem_dat_o;
  logic [DW-1:0]       mem_dat_i;

  axi4_usr_mem_arb #(.NUM_PORT(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .p_awvalid_i(p_awvalid_i), .p_arvalid_i(p_arvalid_i), .p_arlen_i(p_arlen_i),
    .p_wvalid_i(p_wvalid_i), .p_wlast_i(p_wlast_i), .p_rready_i(p_rready_i),
    .p_bready_i(p_bready_i), .p_en_i(p_en_i), .p_wen_i(p_wen_i),
    .p_addr_i(p_addr_i), .p_bm_i(p_bm_i), .p_dat_i(p_dat_i),
    .p_awready_o(p_awready_o), .p_wready_o(p_wready_o), .p_bvalid_o(p_bvalid_o),
    .p_arready_o(p_arready_o), .p_rvalid_o(p_rvalid_o), .p_dat_o(p_dat_o),
    .mem_en_o(mem_en_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_bm_o(mem_bm_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // SRAM model (64 words) and the expected image
  logic [DW-1:0] mem_arr [64];
  logic [DW-1:0] exp_mem [64];
  logic          init_mem;

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'h1357_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  always @(posedge aclk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
    end else if (mem_en_o) begin
      if (mem_wen_o) begin
        for (int j = 0; j < BW; j++)
          if (mem_bm_o[j]) mem_arr[mem_addr_o[5:0]][j*8 +: 8] <= mem_dat_o[j*8 +: 8];
      end else begin
        mem_dat_i <= mem_arr[mem_addr_o[5:0]];
      end
    end
  end

  int n_chk, n_fail;

  // Reference-model state
  int rr_m;
  bit pend_rd [NP];
  bit pend_wr [NP];
  int rd_len  [NP];
  int rd_base [NP];
  int wr_n    [NP];
  int wr_base [NP];
  int rd_stall, b_stall, rst_port;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hs"}, {p_awready_o, p_wready_o, p_bvalid_o, p_arready_o, p_rvalid_o}, 0);
    chk({tag, "_mem"}, {mem_en_o, mem_wen_o, mem_bm_o, mem_addr_o}, 0);
    chk({tag, "_mdat"}, mem_dat_o, 0);
    chk({tag, "_pdat"}, p_dat_o, 0);
  endtask

  task automatic idle_inputs();
    p_awvalid_i = '0; p_arvalid_i = '0; p_arlen_i = '0; p_wvalid_i = '0;
    p_wlast_i = '0; p_rready_i = '0; p_bready_i = '0; p_en_i = '0;
    p_wen_i = '0; p_addr_i = '0; p_bm_i = '0; p_dat_i = '0;
  endtask

  task automatic clear_pend();
    for (int p = 0; p < NP; p++) begin
      pend_rd[p] = 0;
      pend_wr[p] = 0;
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    idle_inputs();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    rr_m = 0;
    clear_pend();
  endtask

  task automatic set_rd(input int p, input int len, input int base);
    pend_rd[p] = 1; rd_len[p] = len; rd_base[p] = base;
  endtask

  task automatic set_wr(input int p, input int n, input int base);
    pend_wr[p] = 1; wr_n[p] = n; wr_base[p] = base;
  endtask

  // Drive one read burst after the ar handshake; optionally reset at a beat
  task automatic read_burst(input int p, input int len, input int base,
                            input int stall, input int rst_beat, output bit aborted);
    int a, s;
    aborted = 0;
    for (int b = 0; b <= len; b++) begin
      a = (base + b) & 63;
      p_en_i[p] = 1'b1;
      p_wen_i[p] = 1'b0;
      p_addr_i[p*AW +: AW] = AW'(a);
      #1 chk("rd_pre_rvalid", p_rvalid_o, 0);
      @(negedge aclk);
      p_en_i[p] = 1'b0;
      s = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int k = 0; k <= s; k++) begin
        p_rready_i[p] = (k == s);
        #1;
        chk("rd_rvalid", p_rvalid_o, NP'(1) << p);
        chk("rd_data", p_dat_o, exp_mem[a]);
        if (b == rst_beat) begin
          aresetn = 1'b0;
          #1 chk_zero("rst_async");
          @(posedge aclk);
          #1 chk_zero("rst_edge");
          aborted = 1;
          return;
        end
        @(negedge aclk);
      end
      p_rready_i[p] = 1'b0;
    end
    #1 chk("rd_done_rvalid", p_rvalid_o, 0);
  endtask

  // Drive one write burst after the aw handshake, then the b response
  task automatic write_burst(input int p, input int n, input int base, input int bstall);
    int a, s;
    logic [DW-1:0] d;
    logic [BW-1:0] m;
    for (int b = 0; b < n; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        p_wvalid_i[p] = 1'b0;
        p_en_i[p] = 1'b0;
        #1 chk("wr_gap_wready", p_wready_o, NP'(1) << p);
        @(negedge aclk);
      end
      a = (base + b) & 63;
      d = $urandom;
      m = BW'($urandom_range(1, 15));
      p_wvalid_i[p] = 1'b1;
      p_wlast_i[p] = (b == n - 1);
      p_en_i[p] = 1'b1;
      p_wen_i[p] = 1'b1;
      p_addr_i[p*AW +: AW] = AW'(a);
      p_dat_i[p*DW +: DW] = d;
      p_bm_i[p*BW +: BW] = m;
      #1;
      chk("wr_wready", p_wready_o, NP'(1) << p);
      chk("wr_mem_en", {mem_en_o, mem_wen_o}, 2'b11);
      chk("wr_mem_addr", mem_addr_o, a);
      chk("wr_mem_dat", {mem_bm_o, mem_dat_o}, {m, d});
      for (int j = 0; j < BW; j++)
        if (m[j]) exp_mem[a][j*8 +: 8] = d[j*8 +: 8];
      @(negedge aclk);
    end
    p_wvalid_i[p] = 1'b0; p_wlast_i[p] = 1'b0; p_en_i[p] = 1'b0; p_wen_i[p] = 1'b0;
    s = (bstall < 0) ? int'($urandom_range(0, 3)) : bstall;
    for (int k = 0; k <= s; k++) begin
      p_bready_i[p] = (k == s);
      #1;
      chk("wr_bvalid", p_bvalid_o, NP'(1) << p);
      chk("wr_resp_mem_en", mem_en_o, 0);
      @(negedge aclk);
    end
    p_bready_i[p] = 1'b0;
    #1 chk("wr_done_bvalid", p_bvalid_o, 0);
  endtask

  // Serve every pending op, checking grant order against the model
  task automatic run_round();
    int g, og, idx;
    bit exp_rd, ord, found, ab;
    for (int p = 0; p < NP; p++) begin
      p_arvalid_i[p] = pend_rd[p];
      p_awvalid_i[p] = pend_wr[p];
      p_arlen_i[p*8 +: 8] = 8'(rd_len[p]);
    end
    forever begin
      g = -1;
      for (int k = 0; k < NP; k++) begin
        idx = (rr_m + k) % NP;
        if (g < 0 && (pend_rd[idx] || pend_wr[idx])) g = idx;
      end
      if (g < 0) break;
      exp_rd = pend_rd[g];
      found = 0;
      for (int c = 0; c < 10 && !found; c++) begin
        #1;
        if ((p_arready_o | p_awready_o) != 0) found = 1;
        else @(negedge aclk);
      end
      if (!found) begin
        chk("gnt_timeout", 0, 1);
        do_reset();
        break;
      end
      ord = (p_arready_o != 0);
      og = 0;
      for (int k = 0; k < NP; k++)
        if ((ord ? p_arready_o[k] : p_awready_o[k]) == 1'b1) og = k;
      chk("gnt_onehot", $countones({p_arready_o, p_awready_o}), 1);
      chk("gnt_port", og, g);
      chk("gnt_is_read", ord, exp_rd);
      @(negedge aclk);
      if (ord) begin
        p_arvalid_i[og] = 1'b0;
        read_burst(og, rd_len[og], rd_base[og], rd_stall, (og == rst_port) ? 2 : -1, ab);
        pend_rd[og] = 0;
        if (ab) begin
          idle_inputs();
          @(negedge aclk);
          aresetn = 1'b1;
          #1 chk_zero("post_rst");
          rr_m = 0;
          clear_pend();
          rst_port = -1;
          break;
        end
      end else begin
        p_awvalid_i[og] = 1'b0;
        write_burst(og, wr_n[og], wr_base[og], b_stall);
        pend_wr[og] = 0;
      end
      rr_m = (og + 1) % NP;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rd_stall = -1; b_stall = -1; rst_port = -1;
    rr_m = 0;
    clear_pend();
    aresetn = 1'b0;
    idle_inputs();
    init_mem = 1'b1;
    for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
    repeat (2) @(negedge aclk);
    init_mem = 1'b0;
    #1 chk_zero("reset");
    @(negedge aclk);
    aresetn = 1'b1;

    // Two simultaneous readers from rr=0, then again to confirm rr wrapped to 0
    set_rd(0, 1, 4); set_rd(1, 1, 8); run_round();
    set_rd(0, 0, 12); set_rd(1, 0, 13); run_round();
    // Single 4-beat read
    set_rd(0, 3, 16); run_round();
    // Two-beat write with bready held low 3 cycles, then read it back
    b_stall = 3; set_wr(1, 2, 20); run_round(); b_stall = -1;
    set_rd(0, 1, 20); run_round();
    // rready low for 5 cycles on one beat
    rd_stall = 5; set_rd(1, 0, 21); run_round(); rd_stall = -1;
    // Read and write requested together from one port
    set_rd(0, 2, 30); set_wr(0, 2, 31); run_round();
    // Longest burst
    set_rd(1, 255, 0); run_round();
    // Reset in the middle of a burst, then both ports request from a clean rr
    set_rd(0, 0, 5); run_round();
    rst_port = 1; set_rd(1, 3, 40); run_round();
    set_rd(0, 0, 41); set_rd(1, 0, 42); run_round();

    // Random traffic
    for (int r = 0; r < 40; r++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 1) == 1) set_rd(p, int'($urandom_range(0, 5)), int'($urandom_range(0, 63)));
        if ($urandom_range(0, 1) == 1) set_wr(p, int'($urandom_range(1, 4)), int'($urandom_range(0, 63)));
      end
      if (!(pend_rd[0] || pend_wr[0] || pend_rd[1] || pend_wr[1]))
        set_rd(int'($urandom_range(0, NP - 1)), 0, int'($urandom_range(0, 63)));
      run_round();
    end

    @(negedge aclk);
    for (int i = 0; i < 64; i++) chk("mem_word", mem_arr[i], exp_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
